// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 fetch stage with single-outstanding imem handshake, one-entry decode buffer and branch redirect
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        resetl,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [10:0] opcode,
    output logic [63:0] instr_pc,
    input  logic        branch,
    input  logic        uncond_branch,
    input  logic        zero,
    input  logic [63:0] branch_pc,
    input  logic [63:0] branch_offset,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;
    state_t      state;
    logic [63:0] pc;
    logic        redirect;
    logic [63:0] target;
    assign redirect    = uncond_branch | (branch & zero);
    assign target      = branch_pc + (branch_offset << 2);
    assign imem_req    = state == FETCH;
    assign imem_addr   = pc;
    assign instr_valid = (state == FULL) & ~redirect;
    assign opcode      = instruction[31:21];
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect) pc <= target;
                end
                FETCH: begin
                    if (redirect) begin
                        pc <= target;
                        if (!imem_rvalid) state <= DRAIN;
                    end else if (imem_rvalid) begin
                        instruction <= imem_rdata;
                        instr_pc    <= pc;
                        pc          <= pc + 64'd4;
                        state       <= FULL;
                    end
                end
                FULL: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (instr_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) pc <= target;
                    if (imem_rvalid) state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        CLK = 0;
    logic        resetl;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [10:0] opcode;
    logic [63:0] instr_pc;
    logic        branch, uncond_branch, zero;
    logic [63:0] branch_pc, branch_offset;
    logic [31:0] fetch_count;
    int          errors = 0;
    int          checks = 0;
    int          lat = 1;
    int          cnt = 0;
    logic        busy = 0;
    logic [63:0] raddr = '0;

    fetch_unit #(.RESET_PC(64'h100)) dut (
        .CLK(CLK), .resetl(resetl),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .opcode(opcode), .instr_pc(instr_pc),
        .branch(branch), .uncond_branch(uncond_branch), .zero(zero),
        .branch_pc(branch_pc), .branch_offset(branch_offset),
        .fetch_count(fetch_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return a == 64'h100 ? 32'h8B020020 : a == 64'h104 ? 32'hCB030041 : {4'hD, a[27:0]};
    endfunction

    always @(posedge CLK) begin
        imem_rvalid <= 1'b0;
        if (busy) begin
            if (cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem(raddr);
                busy        <= 1'b0;
            end else cnt <= cnt - 1;
        end else if (imem_req && !imem_rvalid) begin
            if (lat == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem(imem_addr);
            end else begin
                busy  <= 1'b1;
                cnt   <= lat - 1;
                raddr <= imem_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        resetl = 0; instr_ready = 1; branch = 0; uncond_branch = 0; zero = 0;
        branch_pc = '0; branch_offset = '0;
        repeat (3) tick();
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_cnt", fetch_count, 0);
        check("rst_addr", imem_addr, 64'h100);
        check("rst_instr", instruction, 0);
        resetl = 1;
        #1 check("idle_req", imem_req, 0);
        tick();
        check("req1", imem_req, 1);
        check("addr1", imem_addr, 64'h100);
        tick();
        tick();
        check("valid1", instr_valid, 1);
        check("op1", opcode, 11'h458);
        check("pc1", instr_pc, 64'h100);
        check("ins1", instruction, 32'h8B020020);
        tick();
        check("cnt1", fetch_count, 1);
        check("addr2", imem_addr, 64'h104);
        check("valid_gap", instr_valid, 0);
        tick();
        tick();
        check("valid2", instr_valid, 1);
        check("op2", opcode, 11'h658);
        check("pc2", instr_pc, 64'h104);
        tick();
        check("cnt2", fetch_count, 2);
        check("addr3", imem_addr, 64'h108);
        tick();
        instr_ready = 0;
        tick();
        check("bp_pc0", instr_pc, 64'h108);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid", instr_valid, 1);
            check("bp_pc", instr_pc, 64'h108);
            check("bp_ins", instruction, 32'hD0000108);
            check("bp_req", imem_req, 0);
            check("bp_cnt", fetch_count, 2);
        end
        instr_ready = 1;
        tick();
        check("bp_cnt3", fetch_count, 3);
        check("bp_req1", imem_req, 1);
        check("bp_addr", imem_addr, 64'h10C);
        instr_ready = 0;
        tick();
        tick();
        check("full_pc", instr_pc, 64'h10C);
        branch = 1; zero = 1; branch_pc = 64'h104; branch_offset = '1; instr_ready = 1;
        #1 check("rd_gate", instr_valid, 0);
        tick();
        check("rd_addr", imem_addr, 64'h100);
        check("rd_req", imem_req, 1);
        check("rd_cnt", fetch_count, 3);
        branch = 0; zero = 0; instr_ready = 0;
        tick();
        tick();
        check("nz_pc", instr_pc, 64'h100);
        branch = 1; zero = 0; instr_ready = 1;
        #1 check("nz_valid", instr_valid, 1);
        tick();
        check("nz_addr", imem_addr, 64'h104);
        check("nz_cnt", fetch_count, 4);
        branch = 0;
        lat = 4;
        tick();
        uncond_branch = 1; branch_pc = 64'h200; branch_offset = 64'd3;
        tick();
        check("dr_req", imem_req, 0);
        check("dr_addr", imem_addr, 64'h20C);
        uncond_branch = 0;
        tick();
        tick();
        check("dr_stale", imem_rvalid, 1);
        check("dr_req2", imem_req, 0);
        tick();
        check("dr_req3", imem_req, 1);
        check("dr_addr3", imem_addr, 64'h20C);
        check("dr_valid", instr_valid, 0);
        check("dr_ipc", instr_pc, 64'h100);
        lat = 1;
        tick();
        check("co_rvalid", imem_rvalid, 1);
        uncond_branch = 1; branch_pc = 64'h300; branch_offset = 64'd1;
        tick();
        check("co_req", imem_req, 1);
        check("co_addr", imem_addr, 64'h304);
        uncond_branch = 0;
        tick();
        tick();
        check("co_valid", instr_valid, 1);
        check("co_pc", instr_pc, 64'h304);
        tick();
        check("co_cnt", fetch_count, 5);
        check("co_addr2", imem_addr, 64'h308);
        tick();
        uncond_branch = 1; branch_pc = 64'h0; branch_offset = 64'h3FFF_FFFF_FFFF_FFFF;
        tick();
        check("wr_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        uncond_branch = 0;
        tick();
        tick();
        check("wr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wr_addr0", imem_addr, 64'h0);
        check("wr_cnt", fetch_count, 6);
        lat = 4;
        tick();
        uncond_branch = 1; branch_pc = 64'h400; branch_offset = 64'd0;
        tick();
        check("rd2_req", imem_req, 0);
        check("rd2_addr", imem_addr, 64'h400);
        uncond_branch = 0;
        resetl = 0;
        #1;
        check("ar_req", imem_req, 0);
        check("ar_addr", imem_addr, 64'h100);
        check("ar_valid", instr_valid, 0);
        check("ar_ins", instruction, 0);
        check("ar_op", opcode, 0);
        check("ar_ipc", instr_pc, 0);
        check("ar_cnt", fetch_count, 0);
        repeat (4) tick();
        resetl = 1; lat = 1;
        #1 check("ar_idle", imem_req, 0);
        tick();
        check("ar_req1", imem_req, 1);
        check("ar_addr1", imem_addr, 64'h100);
        tick();
        tick();
        check("ar_valid1", instr_valid, 1);
        check("ar_pc1", instr_pc, 64'h100);
        check("ar_op1", opcode, 11'h458);
        tick();
        check("ar_cnt1", fetch_count, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the LEGv8 datapath. It is the producer side of the opcode interface: it supplies `instruction` and `opcode` (bits [31:21]) to the control decoder. It consumes that decoder's `branch` and `uncond_branch` outputs, together with the ALU `zero` flag, to redirect the PC. It runs a request/response handshake to instruction memory with one request outstanding, a one-entry output buffer with valid/ready toward decode, and a four-state FSM.

## Interface
- `RESET_PC`, 64'h0: PC value loaded on reset.
- `CLK`, input, 1: clock, rising edge.
- `resetl`, input, 1: asynchronous, active-low reset.
- `imem_req`, output, 1: fetch request. Level signal, held with a stable address until `imem_rvalid`.
- `imem_addr`, output, 64: byte address of the fetch.
- `imem_rvalid`, input, 1: response valid. Exactly one pulse per accepted request, at least 1 cycle after `imem_req` first rises.
- `imem_rdata`, input, 32: instruction word, valid with `imem_rvalid`.
- `instr_valid`, output, 1: buffered instruction available.
- `instr_ready`, input, 1: decode accepts. A transfer occurs on `instr_valid & instr_ready`.
- `instruction`, output, 32: buffered instruction word.
- `opcode`, output, 11: `instruction[31:21]`, wired to control `opcode`.
- `instr_pc`, output, 64: address the buffered instruction was fetched from.
- `branch`, input, 1: conditional branch, from control.
- `uncond_branch`, input, 1: unconditional branch, from control.
- `zero`, input, 1: ALU zero flag.
- `branch_pc`, input, 64: PC of the branching instruction.
- `branch_offset`, input, 64: sign-extended word offset.
- `fetch_count`, output, 32: count of completed decode transfers.

## Operation
- `redirect = uncond_branch | (branch & zero)`.
- `target = branch_pc + {branch_offset[61:0], 2'b00}`, modulo 2^64.
- Sequential PC advance: `pc + 4`, modulo 2^64. 0xFFFF_FFFF_FFFF_FFFC wraps to 0x0.
- IDLE: entered on reset. `imem_req` = 0. Goes to FETCH unconditionally next cycle. If `redirect` is high, `pc <= target`.
- FETCH: `imem_req` = 1, `imem_addr` = `pc`.
  - On `imem_rvalid` with no `redirect`: capture `imem_rdata` into `instruction`, set `instr_pc <= pc` and `pc <= pc + 4`, go to FULL.
  - On `redirect` with `imem_rvalid` in the same cycle: discard the data, `pc <= target`, stay in FETCH.
  - On `redirect` without `imem_rvalid`: `pc <= target`, go to DRAIN.
- FULL: `imem_req` = 0. `instr_valid = ~redirect`, so the output is combinationally gated.
  - On transfer: `fetch_count` increments (32-bit wrap), go to FETCH.
  - On `redirect`: drop the buffer, `pc <= target`, go to FETCH. No count increment.
- DRAIN: `imem_req` = 0. Wait for the stale `imem_rvalid`, discard its data, go to FETCH. A `redirect` here updates `pc <= target` and the state stays DRAIN.
- `instruction`, `instr_pc` and `opcode` are held stable whenever `instr_valid` is high and `instr_ready` is low.
- `redirect` has priority over every other event in every state.

## Timing
- Reset values (asynchronous, while `resetl` = 0):
  - state = IDLE, `pc` = `RESET_PC`
  - `imem_req` = 0, `imem_addr` = `RESET_PC`
  - `instr_valid` = 0, `instruction` = 0, `opcode` = 0, `instr_pc` = 0
  - `fetch_count` = 0
- Reset asserted mid-fetch returns to IDLE immediately. Any later `imem_rvalid` for the aborted request is ignored outside FETCH.
- First `imem_req` is high on the first rising edge after `resetl` deasserts, plus one cycle in IDLE.
- Latency: `imem_req` rises at cycle t; `imem_rvalid` arrives at t+L; `instr_valid` rises at t+L+1.
- A transfer at cycle c puts the next `imem_req` high at c+1.
- Peak throughput with L = 1 and `instr_ready` held at 1: one instruction per 3 cycles.
- Redirect takes effect on the next edge. The first request to `target` issues the following cycle, except that in DRAIN it waits for the stale response.

## Test plan
- Reset: `RESET_PC` = 0x100, `resetl` low for 3 cycles → `imem_req` = 0, `instr_valid` = 0, `fetch_count` = 0. After release: IDLE for one cycle, then `imem_req` = 1 with `imem_addr` = 0x100.
- Straight line, L = 1, `instr_ready` = 1: words 0x8B020020 at 0x100 and 0xCB030041 at 0x104 → `opcode` 0x458 with `instr_pc` 0x100, then `opcode` 0x658 with `instr_pc` 0x104. `instr_valid` pulses 3 cycles apart; `fetch_count` = 2.
- Backpressure: `instr_ready` held low for 5 cycles while in FULL → `instruction` and `instr_pc` stable, `imem_req` = 0, `fetch_count` unchanged. `instr_ready` rises → one transfer, `imem_req` high the next cycle.
- Redirect in FULL: `branch` = 1, `zero` = 1, `branch_pc` = 0x104, `branch_offset` = all ones → next `imem_addr` = 0x100, buffer dropped, no count increment. Repeat with `zero` = 0 → sequential fetch continues.
- Redirect in flight: L = 4, `uncond_branch` pulsed 1 cycle after `imem_req` rises, `branch_pc` = 0x200, `branch_offset` = 3 → `imem_req` drops, the stale `imem_rvalid` is discarded, then `imem_req` = 1 with `imem_addr` = 0x20C. Also cover `redirect` coincident with `imem_rvalid` → no DRAIN, immediate request to `target`.
- Wrap: `pc` = 0xFFFF_FFFF_FFFF_FFFC fetched → next `imem_addr` = 0x0. `resetl` asserted while in DRAIN → IDLE, outputs at reset values, late `imem_rvalid` ignored.
